led_display_pattern_gen: RTL and testbench



---
 rtl/led_display_package.sv | 27 ++
 rtl/led_display_pattern_row.sv | 47 ++++
 rtl/led_display_pattern_gen.sv | 64 ++++++
 tb/tb_led_display_pattern_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/led_display_package.sv
// Shared types and constants for the HUB75 test-pattern source: row struct, mode codes, panel geometry.
package led_display_package;

  localparam int ROW_PIXELS  = 32;
  localparam int COL_PIXELS  = 64;
  localparam int SCAN_ADDRS  = ROW_PIXELS / 2;
  localparam int ADDR_W      = $clog2(SCAN_ADDRS);
  localparam int POS_W       = $clog2(COL_PIXELS);

  localparam logic [3:0] PTG_OFF    = 4'd0;
  localparam logic [3:0] PTG_RED    = 4'd1;
  localparam logic [3:0] PTG_GREEN  = 4'd2;
  localparam logic [3:0] PTG_BLUE   = 4'd3;
  localparam logic [3:0] PTG_WHITE  = 4'd4;
  localparam logic [3:0] PTG_BARS   = 4'd5;
  localparam logic [3:0] PTG_SCROLL = 4'd6;

  typedef struct packed {
    logic [COL_PIXELS-1:0] red_a;
    logic [COL_PIXELS-1:0] green_a;
    logic [COL_PIXELS-1:0] blue_a;
    logic [COL_PIXELS-1:0] red_b;
    logic [COL_PIXELS-1:0] green_b;
    logic [COL_PIXELS-1:0] blue_b;
  } rgb_row_t;

endpackage

// File: rtl/led_display_pattern_row.sv
// Combinational pattern lookup: (mode, scan address, scroll pos) -> both half-rows.
// Zero latency, no state, no flow control.
module led_display_pattern_row
  import led_display_package::*;
(
  input  logic [3:0]        mode,
  input  logic [ADDR_W-1:0] address,
  input  logic [POS_W-1:0]  pos,
  output rgb_row_t          row
);

  // Colour code is {b,g,r}; no current pattern varies with display row.
  function automatic logic [2:0] pixel_code(input logic [3:0] m,
                                            input logic [POS_W-1:0] col,
                                            input logic [POS_W-1:0] p);
    logic [2:0] code;
    code = 3'b000;
    case (m)
      PTG_RED:    code = 3'b001;
      PTG_GREEN:  code = 3'b010;
      PTG_BLUE:   code = 3'b100;
      PTG_WHITE:  code = 3'b111;
      PTG_BARS:   code = col[5:3];
      PTG_SCROLL: code = (col == p) ? 3'b111 : 3'b000;
      default:    code = 3'b000;
    endcase
    return code;
  endfunction

  logic unused_address;
  assign unused_address = ^address;

  always_comb begin
    row = '0;
    for (int c = 0; c < COL_PIXELS; c++) begin
      logic [2:0] code;
      code = pixel_code(mode, POS_W'(c), pos);
      row.red_a[c]   = code[0];
      row.green_a[c] = code[1];
      row.blue_a[c]  = code[2];
      row.red_b[c]   = code[0];
      row.green_b[c] = code[1];
      row.blue_b[c]  = code[2];
    end
  end

endmodule

// File: rtl/led_display_pattern_gen.sv
// Test-pattern row source for a 64x32 1:16-scan panel; one registered row per accepted transfer, 1-cycle load latency.
// Stall (valid & !ready) holds row and address exactly; mode is sampled only on load edges.
module led_display_pattern_gen
  import led_display_package::*;
#(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int NUM_ROW_PIXELS = ROW_PIXELS,
  parameter int NUM_COL_PIXELS = COL_PIXELS,
  parameter int ANIM_FREQ      = 10
) (
  input  logic                                clk_in,
  input  logic                                reset_in,
  input  logic [3:0]                          mode_in,
  output rgb_row_t                            row_out,
  output logic                                row_valid_out,
  input  logic                                row_ready_in,
  output logic [$clog2(NUM_ROW_PIXELS/2)-1:0] row_address_out
);

  localparam int TICK_MAX = SYS_CLK_FREQ / ANIM_FREQ - 1;
  localparam int CNT_W    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

  logic [CNT_W-1:0]  anim_cnt;
  logic [POS_W-1:0]  pos;
  logic              tick;
  logic              load;
  logic [ADDR_W-1:0] next_addr;
  rgb_row_t          next_row;

  assign tick = (anim_cnt == CNT_W'(TICK_MAX));
  // Before the first load valid is low and the address is already 0.
  assign load      = !row_valid_out || row_ready_in;
  assign next_addr = row_valid_out ? row_address_out + 1'b1 : '0;

  led_display_pattern_row u_pattern_row (
    .mode    (mode_in),
    .address (next_addr),
    .pos     (pos),
    .row     (next_row)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      row_valid_out   <= 1'b0;
      row_address_out <= '0;
      row_out         <= '0;
      anim_cnt        <= '0;
      pos             <= '0;
    end else begin
      if (tick) begin
        anim_cnt <= '0;
        pos      <= (pos == POS_W'(NUM_COL_PIXELS - 1)) ? '0 : pos + 1'b1;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
      if (load) begin
        row_valid_out   <= 1'b1;
        row_address_out <= next_addr;
        row_out         <= next_row;
      end
    end
  end

endmodule

// File: tb/tb_led_display_pattern_gen.sv
module tb_led_display_pattern_gen;
  import led_display_package::*;

  logic       clk_in = 1'b0;
  logic       reset_in = 1'b1;
  logic [3:0] mode_in = 4'd0;
  logic       row_ready_in = 1'b0;
  rgb_row_t   row_out;
  logic       row_valid_out;
  logic [3:0] row_address_out;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] ONES  = {64{1'b1}};
  localparam logic [63:0] ZERO  = 64'h0;
  localparam logic [63:0] BAR_R = 64'hFF00_FF00_FF00_FF00;
  localparam logic [63:0] BAR_G = 64'hFFFF_0000_FFFF_0000;
  localparam logic [63:0] BAR_B = 64'hFFFF_FFFF_0000_0000;

  led_display_pattern_gen #(
    .SYS_CLK_FREQ   (1000),
    .NUM_ROW_PIXELS (32),
    .NUM_COL_PIXELS (64),
    .ANIM_FREQ      (100)
  ) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .mode_in         (mode_in),
    .row_out         (row_out),
    .row_valid_out   (row_valid_out),
    .row_ready_in    (row_ready_in),
    .row_address_out (row_address_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic rgb_row_t mk_row(input logic [63:0] r, input logic [63:0] g, input logic [63:0] b);
    rgb_row_t x;
    x.red_a = r; x.green_a = g; x.blue_a = b;
    x.red_b = r; x.green_b = g; x.blue_b = b;
    return x;
  endfunction

  // Holds reset for two cycles, then releases it with the given mode; the next edge loads address 0.
  task automatic do_reset(input logic [3:0] m, input logic rdy);
    @(negedge clk_in);
    reset_in = 1'b1;
    row_ready_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    mode_in = m;
    row_ready_in = rdy;
    reset_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_reset;
    rgb_row_t exp;
    logic [3:0] exp_addr;
    @(negedge clk_in);
    reset_in = 1'b1;
    mode_in = PTG_RED;
    row_ready_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    checks++;
    if (row_valid_out !== 1'b0 || row_address_out !== 4'd0 || row_out !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b addr=%0d row_nonzero=%b, required valid=0 addr=0 row=0",
               row_valid_out, row_address_out, |row_out);
    end
    reset_in = 1'b0;
    @(negedge clk_in);
    exp = mk_row(ONES, ZERO, ZERO);
    checks++;
    if (row_valid_out !== 1'b1 || row_address_out !== 4'd0 || row_out !== exp) begin
      failures++;
      $display("FAIL first_load: valid=%b addr=%0d row=%h, required valid=1 addr=0 row=%h",
               row_valid_out, row_address_out, row_out, exp);
    end
    exp_addr = 4'd0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_in);
      exp_addr = exp_addr + 4'd1;
      checks++;
      if (row_address_out !== exp_addr || row_valid_out !== 1'b1 || row_out !== exp) begin
        failures++;
        $display("FAIL addr_sequence[%0d]: addr=%0d valid=%b, required addr=%0d valid=1", i,
                 row_address_out, row_valid_out, exp_addr);
      end
    end
  endtask

  task automatic test_handshake;
    rgb_row_t exp;
    logic [3:0] exp_addr;
    do_reset(PTG_WHITE, 1'b0);
    exp = mk_row(ONES, ONES, ONES);
    exp_addr = 4'd0;
    for (int i = 0; i < 8; i++) begin
      row_ready_in = (i % 2 == 0);
      @(negedge clk_in);
      if (i % 2 == 0) exp_addr = exp_addr + 4'd1;
      checks++;
      if (row_address_out !== exp_addr || row_out !== exp || row_valid_out !== 1'b1) begin
        failures++;
        $display("FAIL handshake[%0d]: addr=%0d valid=%b, required addr=%0d valid=1 white", i,
                 row_address_out, row_valid_out, exp_addr);
      end
    end
    row_ready_in = 1'b0;
  endtask

  task automatic test_patterns;
    logic [3:0]  modes [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd15};
    logic [63:0] er    [8] = '{ZERO, ONES, ZERO, ZERO, ONES, BAR_R, ZERO, ZERO};
    logic [63:0] eg    [8] = '{ZERO, ZERO, ONES, ZERO, ONES, BAR_G, ZERO, ZERO};
    logic [63:0] eb    [8] = '{ZERO, ZERO, ZERO, ONES, ONES, BAR_B, ZERO, ZERO};
    rgb_row_t exp;
    do_reset(PTG_OFF, 1'b1);
    for (int m = 0; m < 8; m++) begin
      mode_in = modes[m];
      exp = mk_row(er[m], eg[m], eb[m]);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk_in);
        checks++;
        if (row_out !== exp) begin
          failures++;
          $display("FAIL pattern_mode%0d[%0d]: row=%h, required %h", modes[m], k, row_out, exp);
        end
      end
      if (modes[m] == PTG_BARS) begin
        checks++;
        if (row_out.red_a[15:8] !== 8'hFF || row_out.green_a[15:8] !== 8'h00 ||
            row_out.blue_a[15:8] !== 8'h00 || row_out.red_b[63:56] !== 8'hFF ||
            row_out.green_b[63:56] !== 8'hFF || row_out.blue_b[63:56] !== 8'hFF) begin
          failures++;
          $display("FAIL bars_columns: r[15:8]=%h g[15:8]=%h b[15:8]=%h rgb_b[63:56]=%h/%h/%h, required ff/00/00 ff/ff/ff",
                   row_out.red_a[15:8], row_out.green_a[15:8], row_out.blue_a[15:8],
                   row_out.red_b[63:56], row_out.green_b[63:56], row_out.blue_b[63:56]);
        end
      end
    end
  endtask

  task automatic test_stall_mode;
    rgb_row_t g_row;
    rgb_row_t b_row;
    g_row = mk_row(ZERO, ONES, ZERO);
    b_row = mk_row(ZERO, ZERO, ONES);
    do_reset(PTG_GREEN, 1'b0);
    mode_in = PTG_BLUE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      checks++;
      if (row_out !== g_row || row_address_out !== 4'd0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: addr=%0d row=%h, required addr=0 green", k, row_address_out, row_out);
      end
    end
    row_ready_in = 1'b1;
    @(negedge clk_in);
    row_ready_in = 1'b0;
    checks++;
    if (row_out !== b_row || row_address_out !== 4'd1) begin
      failures++;
      $display("FAIL stall_mode_change: addr=%0d row=%h, required addr=1 blue", row_address_out, row_out);
    end
  endtask

  // Row loaded on edge k after release carries pos = ((k-1)/10) mod 64.
  task automatic test_scroll;
    rgb_row_t exp;
    logic [5:0] exp_pos;
    do_reset(PTG_SCROLL, 1'b1);
    for (int k = 1; k <= 645; k++) begin
      if (k > 1) @(negedge clk_in);
      if (k <= 2 || k % 10 == 0 || k % 10 == 1 || k > 630) begin
        exp_pos = 6'(((k - 1) / 10) % 64);
        exp = mk_row(64'h1 << exp_pos, 64'h1 << exp_pos, 64'h1 << exp_pos);
        checks++;
        if (row_out !== exp) begin
          failures++;
          $display("FAIL scroll_edge%0d: row=%h, required single bit at column %0d", k, row_out, exp_pos);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(PTG_RED, 1'b1);
    repeat (3) @(negedge clk_in);
    row_ready_in = 1'b0;
    reset_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (row_valid_out !== 1'b0 || row_address_out !== 4'd0 || row_out !== '0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b addr=%0d row_nonzero=%b, required valid=0 addr=0 row=0",
               row_valid_out, row_address_out, |row_out);
    end
    reset_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_patterns();
    test_stall_mode();
    test_scroll();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
